// File: rtl/vga_timing_monitor.sv
// On-board checker for the 800x600@72 VGA stream: measures sync period/width,
// flags timing and blanking violations, counts locked frames and CRCs the picture.
module vga_timing_monitor #(
    parameter int unsigned H_TOTAL  = 1040,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_TOTAL  = 666,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned V_ACTIVE = 600
) (
    input  logic        clk,
    input  logic        n_rst_async,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        clear,
    output logic        locked,
    output logic        err_hperiod,
    output logic        err_hwidth,
    output logic        err_vperiod,
    output logic        err_vwidth,
    output logic        err_blank,
    output logic [15:0] frame_count,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    localparam logic [11:0] CNT_MAX = '1;
    localparam logic [11:0] HT      = 12'(H_TOTAL);
    localparam logic [11:0] HS      = 12'(H_SYNC);
    localparam logic [11:0] VT      = 12'(V_TOTAL);
    localparam logic [11:0] VS      = 12'(V_SYNC);
    localparam logic [11:0] HA_LO   = 12'(H_SYNC + H_BP + 1);
    localparam logic [11:0] HA_HI   = 12'(H_SYNC + H_BP + H_ACTIVE + 1);
    localparam logic [11:0] VA_LO   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] VA_HI   = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH,
        SYNCING,
        LOCKED
    } state_t;

    state_t      state;
    logic        hs_prev, vs_prev;
    logic [11:0] hcnt, hw, vcnt, vw;
    logic [11:0] vcnt_base, vcnt_next, vw_base, vw_next;
    logic [15:0] crc, crc_px, crc_cur;
    logic        hs_rise, hs_fall, vs_rise, vs_fall;
    logic        m_hper, m_hw, m_vper, m_vw, any_mis;
    logic        active, rgb_any;

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
        crc_bit = {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        hs_rise = vga_hsync & ~hs_prev;
        hs_fall = ~vga_hsync & hs_prev;
        vs_rise = vga_vsync & ~vs_prev;
        vs_fall = ~vga_vsync & vs_prev;

        m_hper  = hs_rise && (hcnt != HT);
        m_hw    = hs_fall && (hw != HS);
        m_vper  = vs_rise && (vcnt != VT);
        m_vw    = vs_fall && (vw != VS);
        any_mis = m_hper | m_hw | m_vper | m_vw;

        active  = (hcnt >= HA_LO) && (hcnt < HA_HI) && (vcnt >= VA_LO) && (vcnt < VA_HI);
        rgb_any = vga_r | vga_g | vga_b;

        crc_px  = crc_bit(crc_bit(crc_bit(crc, vga_r), vga_g), vga_b);
        crc_cur = active ? crc_px : crc;

        // An hsync rise coinciding with the vsync rise is counted as the first line of the new frame.
        vcnt_base = vs_rise ? '0 : vcnt;
        vcnt_next = (hs_rise && (vcnt_base != CNT_MAX)) ? vcnt_base + 12'd1 : vcnt_base;
        vw_base   = vs_rise ? '0 : vw;
        vw_next   = (hs_rise && vga_vsync && (vw_base != CNT_MAX)) ? vw_base + 12'd1 : vw_base;
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            hcnt    <= '0;
            hw      <= '0;
            vcnt    <= '0;
            vw      <= '0;
            crc     <= CRC_INIT;
        end else begin
            hs_prev <= vga_hsync;
            vs_prev <= vga_vsync;
            if (hs_rise)
                hcnt <= 12'd1;
            else if (hcnt != CNT_MAX)
                hcnt <= hcnt + 12'd1;
            if (vga_hsync) begin
                if (hs_rise)
                    hw <= 12'd1;
                else if (hw != CNT_MAX)
                    hw <= hw + 12'd1;
            end
            vcnt <= vcnt_next;
            vw   <= vw_next;
            crc  <= vs_rise ? CRC_INIT : crc_cur;
        end
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            err_hperiod <= 1'b0;
            err_hwidth  <= 1'b0;
            err_vperiod <= 1'b0;
            err_vwidth  <= 1'b0;
            err_blank   <= 1'b0;
            frame_count <= '0;
            frame_crc   <= '0;
            crc_valid   <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (clear) begin
                state       <= SEARCH;
                locked      <= 1'b0;
                err_hperiod <= 1'b0;
                err_hwidth  <= 1'b0;
                err_vperiod <= 1'b0;
                err_vwidth  <= 1'b0;
                err_blank   <= 1'b0;
                frame_count <= '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (vs_rise)
                            state <= SYNCING;
                    end
                    SYNCING: begin
                        if (any_mis) begin
                            state <= SEARCH;
                        end else if (vs_rise) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (any_mis) begin
                            err_hperiod <= err_hperiod | m_hper;
                            err_hwidth  <= err_hwidth  | m_hw;
                            err_vperiod <= err_vperiod | m_vper;
                            err_vwidth  <= err_vwidth  | m_vw;
                            locked      <= 1'b0;
                            state       <= SEARCH;
                        end else if (vs_rise) begin
                            frame_crc   <= crc_cur;
                            crc_valid   <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                        if (rgb_any && !active)
                            err_blank <= 1'b1;
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Frame-level bench for vga_timing_monitor on a reduced raster: an ideal sync generator
// with injectable faults, a pixel CRC model and a scoreboard of expected frame results.
module tb_vga_timing_monitor;

    localparam int HT = 40, HS = 6, HBP = 4, HA = 24;
    localparam int VT = 20, VS = 2, VBP = 3, VA = 12;

    logic        clk;
    logic        n_rst_async;
    logic        vga_r, vga_g, vga_b, vga_hsync, vga_vsync, clear;
    logic        locked, err_hperiod, err_hwidth, err_vperiod, err_vwidth, err_blank;
    logic [15:0] frame_count, frame_crc;
    logic        crc_valid;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .n_rst_async(n_rst_async),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .clear(clear),
        .locked(locked), .err_hperiod(err_hperiod), .err_hwidth(err_hwidth),
        .err_vperiod(err_vperiod), .err_vwidth(err_vwidth), .err_blank(err_blank),
        .frame_count(frame_count), .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] crc;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] model_crc, exp_fc, last_exp_crc;
    logic [15:0] closed_crc, black_crc, red_crc;
    logic        snap_locked;
    logic [4:0]  snap_err;
    logic [15:0] snap_fc, snap_crc;

    // Per-frame fault/event controls; -1 disables.
    int       o_long, o_short_hs, o_vs_lines, o_lines;
    int       o_px_l, o_px_c, o_clr_l, o_clr_c, o_snap_l, o_snap_c, o_rst_l, o_rst_c;
    logic [2:0] o_px_rgb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [2:0] rgb);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 2; i >= 0; i--) begin
            fb = c[15] ^ rgb[i];
            c  = {c[14:0], 1'b0};
            if (fb)
                c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Column c of line l (c=0 is the hsync rise) sees hcnt=c, vcnt=l+1, so x=c-1, y=l+1.
    function automatic bit in_window(input int l, input int c);
        int x, y;
        x = c - 1;
        y = l + 1;
        return (c >= 1) && (x >= HS + HBP) && (x < HS + HBP + HA) &&
               (y >= VS + VBP) && (y < VS + VBP + VA);
    endfunction

    function automatic logic [4:0] errs();
        return {err_hperiod, err_hwidth, err_vperiod, err_vwidth, err_blank};
    endfunction

    task automatic defaults();
        o_long = -1; o_short_hs = -1; o_vs_lines = VS; o_lines = VT;
        o_px_l = -1; o_px_c = -1; o_px_rgb = 3'b000;
        o_clr_l = -1; o_clr_c = -1; o_snap_l = -1; o_snap_c = -1;
        o_rst_l = -1; o_rst_c = -1;
    endtask

    task automatic frame(input bit closes);
        int len, hlen;
        logic [2:0] rgb;
        exp_t e;
        for (int l = 0; l < o_lines; l++) begin
            len  = (l == o_long) ? HT + 1 : HT;
            hlen = (l == o_short_hs) ? HS - 1 : HS;
            for (int c = 0; c < len; c++) begin
                rgb = (l == o_px_l && c == o_px_c) ? o_px_rgb : 3'b000;
                if (l == 0 && c == 0) begin
                    if (closes) begin
                        exp_fc       = exp_fc + 16'd1;
                        e.crc        = model_crc;
                        e.fc         = exp_fc;
                        last_exp_crc = model_crc;
                        sb.push_back(e);
                    end
                    model_crc = 16'hFFFF;
                end
                if (in_window(l, c))
                    model_crc = crc_model(model_crc, rgb);
                vga_hsync = (c < hlen);
                vga_vsync = (l < o_vs_lines);
                {vga_r, vga_g, vga_b} = rgb;
                clear = (l == o_clr_l && c == o_clr_c);
                if (clear)
                    exp_fc = '0;
                if (l == o_rst_l && c == o_rst_c + 3)
                    n_rst_async = 1'b1;
                if (l == o_rst_l && c == o_rst_c) begin
                    n_rst_async = 1'b0;
                    exp_fc      = '0;
                    #1;
                    check("arst_locked", locked, 0);
                    check("arst_errs", errs(), 0);
                    check("arst_fc", frame_count, 0);
                    check("arst_crc", frame_crc, 0);
                    check("arst_valid", crc_valid, 0);
                end
                @(posedge clk);
                #1;
                if (l == 0 && c == 0)
                    closed_crc = frame_crc;
                if (l == o_snap_l && c == o_snap_c) begin
                    snap_locked = locked;
                    snap_err    = errs();
                    snap_fc     = frame_count;
                    snap_crc    = frame_crc;
                end
            end
        end
    endtask

    task automatic relock(input string tag);
        defaults();
        frame(1'b0);
        o_snap_l = 0; o_snap_c = 0;
        frame(1'b0);
        check(tag, snap_locked, 1);
        defaults();
    endtask

    // Scoreboard consumer: every crc_valid pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (crc_valid) begin
                if (sb.size() == 0) begin
                    check("crc_valid_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("frame_crc", frame_crc, e.crc);
                    check("frame_count", frame_count, e.fc);
                end
            end
        end
    end

    initial begin
        defaults();
        n_rst_async = 1'b0;
        {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, clear} = '0;
        model_crc = 16'hFFFF;
        exp_fc    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_errs", errs(), 0);
        check("rst_fc", frame_count, 0);
        check("rst_crc", frame_crc, 0);
        check("rst_valid", crc_valid, 0);
        n_rst_async = 1'b1;
        @(posedge clk);
        #1;

        // Ideal black frames: lock one cycle after the 2nd vsync rise.
        o_snap_l = 0; o_snap_c = 0;
        frame(1'b0);
        check("lock_rise1", snap_locked, 0);
        frame(1'b0);
        check("lock_rise2", snap_locked, 1);
        defaults();
        frame(1'b1);
        frame(1'b1);
        check("ideal_errs", errs(), 0);
        check("ideal_fc", frame_count, 2);
        check("ideal_locked", locked, 1);

        // Long line.
        o_long = 5; o_snap_l = 6; o_snap_c = 0;
        frame(1'b1);
        check("hper_locked", snap_locked, 0);
        check("hper_errs", snap_err, 5'b10000);
        relock("hper_relock");

        // Clear on the same cycle as a short hsync pulse.
        o_short_hs = 3; o_clr_l = 3; o_clr_c = HS - 1; o_snap_l = 3; o_snap_c = HS - 1;
        frame(1'b1);
        check("clr_errs", snap_err, 0);
        check("clr_fc", snap_fc, 0);
        check("clr_locked", snap_locked, 0);
        check("clr_crc_hold", snap_crc, last_exp_crc);
        relock("clr_relock");

        // Short hsync pulse alone.
        o_short_hs = 3; o_snap_l = 3; o_snap_c = HS - 1; o_clr_l = 10; o_clr_c = 0;
        frame(1'b1);
        check("hw_errs", snap_err, 5'b01000);
        check("hw_locked", snap_locked, 0);
        relock("hw_relock");

        // Short vsync pulse.
        o_vs_lines = VS - 1; o_snap_l = VS - 1; o_snap_c = 0; o_clr_l = 10; o_clr_c = 0;
        frame(1'b1);
        check("vw_errs", snap_err, 5'b00010);
        check("vw_locked", snap_locked, 0);
        relock("vw_relock");

        // One-line-long frame, detected at the following vsync rise.
        o_lines = VT + 1;
        frame(1'b1);
        defaults();
        o_snap_l = 0; o_snap_c = 0; o_clr_l = 10; o_clr_c = 0;
        frame(1'b0);
        check("vper_errs", snap_err, 5'b00100);
        check("vper_locked", snap_locked, 0);
        relock("vper_relock");

        // Pulse on the first active pixel: legal, enters the CRC.
        o_px_l = VS + VBP - 1; o_px_c = HS + HBP + 1; o_px_rgb = 3'b010;
        o_snap_l = o_px_l; o_snap_c = o_px_c;
        frame(1'b1);
        check("corner_errs", snap_err, 0);
        check("corner_locked", snap_locked, 1);
        defaults();
        frame(1'b1);
        o_px_l = VS + VBP - 1; o_px_c = HS + HBP + 1; o_px_rgb = 3'b100;
        frame(1'b1);
        black_crc = closed_crc;
        defaults();
        frame(1'b1);
        red_crc = closed_crc;
        check("crc_black_vs_red_differ", (black_crc != red_crc), 1);

        // Pixel at x=0 of an active line: blanking error, lock kept.
        o_px_l = 8; o_px_c = 1; o_px_rgb = 3'b010; o_snap_l = 8; o_snap_c = 1;
        frame(1'b1);
        check("blank_errs", snap_err, 5'b00001);
        check("blank_locked", snap_locked, 1);
        check("blank_locked_end", locked, 1);

        // Asynchronous reset mid-line, then relock after two vsync rises.
        defaults();
        o_rst_l = 5; o_rst_c = 20;
        frame(1'b1);
        relock("arst_relock");
        frame(1'b1);
        check("final_fc", frame_count, 1);
        check("final_errs", errs(), 0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
